dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store path and the 256x8 byte-wide data memory.
- Holds 8 lines of 4 bytes.
- Sequences line write-back and fill as 4 single-byte memory transfers each.
- Presents the same read/write/busywait handshake to the CPU as the raw memory, so the CPU is unchanged.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_line_store.sv | 103 ++++++++++
 rtl/dcache_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped data cache controller.
//   state_t       : controller states IDLE / WB / FETCH / UPDATE
//   ADDR_W/DATA_W : CPU and memory address / data widths
//   LINES_DEF, BLOCK_BYTES_DEF : default geometry (8 lines of 4 bytes)
//   TAG_W, INDEX_W, OFFSET_W   : address split derived from the defaults
//   STATS_W       : width of the optional hit/miss counters
//   sat_inc()     : saturating increment used by the counters
package dcache_pkg;

  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 8;
  localparam int LINES_DEF       = 8;
  localparam int BLOCK_BYTES_DEF = 4;
  localparam int INDEX_W         = $clog2(LINES_DEF);
  localparam int OFFSET_W        = $clog2(BLOCK_BYTES_DEF);
  localparam int TAG_W           = ADDR_W - INDEX_W - OFFSET_W;
  localparam int STATS_W         = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FETCH  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: data, tag, valid and dirty storage for the cache.
// Ports:
//   clk, srst            : clock, synchronous clear of all valid/dirty bits
//   index                : line selected for every read and write port
//   rd_offset/rd_data    : combinational CPU-side byte read
//   wb_offset/wb_data    : combinational byte read used for write-back
//   line_tag/valid/dirty : metadata of the selected line
//   wr_*                 : CPU byte write (also marks the line dirty)
//   fill_*               : byte write of data returned from memory
//   meta_*               : tag / valid / dirty update of the selected line
// Data and tags are deliberately not cleared by srst.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES       = LINES_DEF,
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int IDX_W       = $clog2(LINES),
  parameter int OFF_W       = $clog2(BLOCK_BYTES),
  parameter int TG_W        = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [IDX_W-1:0]  index,
  input  logic [OFF_W-1:0]  rd_offset,
  output logic [DATA_W-1:0] rd_data,
  input  logic [OFF_W-1:0]  wb_offset,
  output logic [DATA_W-1:0] wb_data,
  output logic [TG_W-1:0]   line_tag,
  output logic              line_valid,
  output logic              line_dirty,
  input  logic              wr_en,
  input  logic [OFF_W-1:0]  wr_offset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill_en,
  input  logic [OFF_W-1:0]  fill_offset,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              meta_en,
  input  logic [TG_W-1:0]   meta_tag,
  input  logic              meta_valid,
  input  logic              meta_dirty
);

  logic [DATA_W-1:0] data_mem [LINES][BLOCK_BYTES];
  logic [TG_W-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]  valid_vec;
  logic [LINES-1:0]  dirty_vec;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[index][wr_offset] <= wr_data;
    end
    if (fill_en) begin
      data_mem[index][fill_offset] <= fill_data;
    end
    if (meta_en) begin
      tag_mem[index] <= meta_tag;
    end
  end

  // Per-line valid/dirty flops so that only these bits see the clear.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic sel;
      logic valid_q, valid_d;
      logic dirty_q, dirty_d;

      assign sel = (index == IDX_W'(gi));

      always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (sel && meta_en) begin
          valid_d = meta_valid;
          dirty_d = meta_dirty;
        end
        if (sel && wr_en) begin
          dirty_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (srst) begin
          valid_q <= 1'b0;
          dirty_q <= 1'b0;
        end else begin
          valid_q <= valid_d;
          dirty_q <= dirty_d;
        end
      end

      assign valid_vec[gi] = valid_q;
      assign dirty_vec[gi] = dirty_q;
    end
  endgenerate

  assign rd_data    = data_mem[index][rd_offset];
  assign wb_data    = data_mem[index][wb_offset];
  assign line_tag   = tag_mem[index];
  assign line_valid = valid_vec[index];
  assign line_dirty = dirty_vec[index];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache between
// the CPU load/store path and a byte-wide memory with a busywait handshake.
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   read, write, address,
//   writedata, readdata, busywait : CPU side, same handshake as raw memory
//   mem_read, mem_write, mem_address,
//   mem_writedata, mem_readdata,
//   mem_busywait                  : memory side, one byte per transfer
//   hit_count, miss_count         : saturating statistics, present only when
//                                   DCACHE_STATS_EN is defined
// The CPU must hold its request stable while busywait is high; nothing from
// the CPU side is latched here.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES       = LINES_DEF,
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  output logic               busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_writedata,
  input  logic [DATA_W-1:0]  mem_readdata,
  input  logic               mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [STATS_W-1:0] hit_count,
  output logic [STATS_W-1:0] miss_count
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(BLOCK_BYTES);
  localparam int TW = ADDR_W - IW - OW;

  state_t            state_q, state_d;
  logic [OW-1:0]     beat_q, beat_d;
  logic              mem_busywait_q, mem_busywait_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;

  logic [TW-1:0]     cpu_tag;
  logic [IW-1:0]     cpu_index;
  logic [OW-1:0]     cpu_offset;
  logic              req;
  logic              hit;
  logic              done;
  logic              last_beat;

  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wb_data;
  logic [TW-1:0]     line_tag;
  logic              line_valid;
  logic              line_dirty;
  logic              wr_en;
  logic              fill_en;
  logic              meta_en;
  logic [TW-1:0]     meta_tag;
  logic              meta_valid;
  logic              meta_dirty;

  assign cpu_tag    = address[ADDR_W-1 -: TW];
  assign cpu_index  = address[OW +: IW];
  assign cpu_offset = address[OW-1:0];
  assign req        = read ^ write;
  assign hit        = line_valid && (line_tag == cpu_tag);
  // A beat finishes on the falling edge of the memory's busywait.
  assign done       = mem_busywait_q && !mem_busywait;
  assign last_beat  = (beat_q == OW'(BLOCK_BYTES - 1));

  dcache_line_store #(
    .LINES       (LINES),
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_store (
    .clk         (clock),
    .srst        (reset),
    .index       (cpu_index),
    .rd_offset   (cpu_offset),
    .rd_data     (rd_data),
    .wb_offset   (beat_d),
    .wb_data     (wb_data),
    .line_tag    (line_tag),
    .line_valid  (line_valid),
    .line_dirty  (line_dirty),
    .wr_en       (wr_en),
    .wr_offset   (cpu_offset),
    .wr_data     (writedata),
    .fill_en     (fill_en),
    .fill_offset (beat_q),
    .fill_data   (mem_readdata),
    .meta_en     (meta_en),
    .meta_tag    (meta_tag),
    .meta_valid  (meta_valid),
    .meta_dirty  (meta_dirty)
  );

  // State register (memory-side outputs are registered alongside).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      mem_busywait_q  <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      mem_busywait_q  <= mem_busywait_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = (line_valid && line_dirty) ? WB : FETCH;
          beat_d  = '0;
        end
      end
      WB: begin
        if (done) begin
          if (last_beat) begin
            state_d = FETCH;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FETCH: begin
        if (done) begin
          if (last_beat) begin
            state_d = UPDATE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: CPU handshake, line store controls, memory request.
  always_comb begin
    busywait        = 1'b0;
    readdata        = '0;
    wr_en           = 1'b0;
    fill_en         = 1'b0;
    meta_en         = 1'b0;
    meta_tag        = line_tag;
    meta_valid      = line_valid;
    meta_dirty      = line_dirty;
    mem_busywait_d  = mem_busywait;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_address_d   = '0;
    mem_writedata_d = '0;

    case (state_q)
      IDLE, UPDATE: begin
        // UPDATE always hits: the line was just filled for this request.
        if (req && hit) begin
          if (read) begin
            readdata = rd_data;
          end else begin
            wr_en = 1'b1;
          end
        end else if (req && (state_q == IDLE)) begin
          busywait = 1'b1;
        end
      end
      WB: begin
        busywait = 1'b1;
        if (done && last_beat) begin
          meta_en    = 1'b1;
          meta_dirty = 1'b0;
        end
      end
      FETCH: begin
        busywait = 1'b1;
        if (done) begin
          fill_en = 1'b1;
          if (last_beat) begin
            meta_en    = 1'b1;
            meta_tag   = cpu_tag;
            meta_valid = 1'b1;
            meta_dirty = 1'b0;
          end
        end
      end
      default: busywait = 1'b0;
    endcase

    // The request drops for one cycle after each completed beat so the
    // memory sees a fresh access; address/data only move while it is low.
    if (state_d == WB) begin
      mem_write_d     = !done;
      mem_address_d   = {line_tag, cpu_index, beat_d};
      mem_writedata_d = wb_data;
    end else if (state_d == FETCH) begin
      mem_read_d    = !done;
      mem_address_d = {cpu_tag, cpu_index, beat_d};
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

`ifdef DCACHE_STATS_EN
  logic [STATS_W-1:0] hit_count_q, hit_count_d;
  logic [STATS_W-1:0] miss_count_q, miss_count_d;

  // Only IDLE decisions count; the access finished in UPDATE is not a hit.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == IDLE) && req) begin
      if (hit) begin
        hit_count_d = sat_inc(hit_count_q);
      end else begin
        miss_count_d = sat_inc(miss_count_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl with a behavioural
// memory (random latency) and a transaction-level cache reference model.
// Build with DCACHE_STATS_EN defined to also exercise the counters.
module tb_dcache_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_address;
  logic [7:0]  mem_writedata;
  logic [7:0]  mem_readdata;
  logic        mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  dcache_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } op_t;

  function automatic op_t mk_op(input logic w, input logic [7:0] a, input logic [7:0] d);
    op_t o;
    o.w = w;
    o.a = a;
    o.d = d;
    return o;
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 73) ^ 92);
  endfunction

  // ---------------- behavioural memory ----------------
  logic [7:0] mem [256];
  bit         mem_loaded = 1'b0;
  logic       req_prev;
  logic [7:0] addr_prev;
  int         lat_cnt;
  int         proto_err = 0;
  op_t        mem_log[$];

  always @(posedge clock) begin
    if (reset) begin
      mem_busywait <= 1'b0;
      mem_readdata <= 8'h00;
      req_prev     <= 1'b0;
      addr_prev    <= 8'h00;
      lat_cnt      <= 0;
      if (!mem_loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        mem_loaded <= 1'b1;
      end
    end else begin
      if (mem_read && mem_write) proto_err <= proto_err + 1;
      if (req_prev && (mem_read || mem_write) && (mem_address != addr_prev))
        proto_err <= proto_err + 1;
      if (mem_busywait) begin
        if (lat_cnt == 0) begin
          mem_busywait <= 1'b0;
          if (mem_write) begin
            mem[mem_address] <= mem_writedata;
            mem_log.push_back(mk_op(1'b1, mem_address, mem_writedata));
          end else begin
            mem_readdata <= mem[mem_address];
            mem_log.push_back(mk_op(1'b0, mem_address, mem[mem_address]));
          end
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end else if ((mem_read || mem_write) && !req_prev) begin
        mem_busywait <= 1'b1;
        lat_cnt      <= int'($urandom_range(0, 2));
      end
      req_prev  <= mem_read || mem_write;
      addr_prev <= mem_address;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  logic       m_valid [8];
  logic       m_dirty [8];
  logic [2:0] m_tag   [8];
  logic [7:0] m_data  [8][4];
  int         m_hits = 0;
  int         m_misses = 0;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic idle();
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
  endtask

  // One CPU transaction: model predicts, DUT is driven and checked.
  task automatic run_access(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [7:0] wd, input string name);
    logic [2:0] idx;
    logic [2:0] tg;
    logic [1:0] off;
    logic       h;
    logic       exp_busy;
    logic [7:0] exp_rd;
    logic [7:0] ea;
    op_t        exp_ops[$];
    op_t        got;
    int         base;
    int         cyc;
    idx = a[4:2];
    tg  = a[7:5];
    off = a[1:0];
    exp_busy = 1'b0;
    exp_rd   = 8'h00;
    if (rd ^ wr) begin
      h = m_valid[idx] && (m_tag[idx] == tg);
      exp_busy = !h;
      if (h) begin
        m_hits++;
      end else begin
        m_misses++;
        if (m_valid[idx] && m_dirty[idx]) begin
          for (int b = 0; b < 4; b++) begin
            ea = {m_tag[idx], idx, 2'(b)};
            exp_ops.push_back(mk_op(1'b1, ea, m_data[idx][b]));
            ref_mem[ea] = m_data[idx][b];
          end
        end
        for (int b = 0; b < 4; b++) begin
          ea = {tg, idx, 2'(b)};
          exp_ops.push_back(mk_op(1'b0, ea, ref_mem[ea]));
          m_data[idx][b] = ref_mem[ea];
        end
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b0;
        m_tag[idx]   = tg;
      end
      if (rd) begin
        exp_rd = m_data[idx][off];
      end else begin
        m_data[idx][off] = wd;
        m_dirty[idx]     = 1'b1;
      end
    end

    base = mem_log.size();
    @(negedge clock);
    read      = rd;
    write     = wr;
    address   = a;
    writedata = wd;
    #1;
    vectors++;
    if (busywait !== exp_busy) begin
      miscompares++;
      $display("FAIL %s busywait_first: got %b expected %b", name, busywait, exp_busy);
    end
    if (exp_busy) begin
      @(negedge clock);
      #1;
      vectors++;
      if ((mem_read | mem_write) !== 1'b1) begin
        miscompares++;
        $display("FAIL %s mem_req_start: got rd=%b wr=%b expected a request", name, mem_read, mem_write);
      end
      cyc = 0;
      while (busywait !== 1'b0 && cyc < 500) begin
        @(negedge clock);
        #1;
        cyc++;
      end
      vectors++;
      if (busywait !== 1'b0) begin
        miscompares++;
        $display("FAIL %s completion: busywait=%b after %0d cycles, expected 0", name, busywait, cyc);
      end
    end
    if (rd && !wr) begin
      vectors++;
      if (readdata !== exp_rd) begin
        miscompares++;
        $display("FAIL %s readdata: got %h expected %h", name, readdata, exp_rd);
      end
    end
    @(posedge clock);
    vectors++;
    if (mem_log.size() - base != exp_ops.size()) begin
      miscompares++;
      $display("FAIL %s mem_traffic_count: got %0d transfers expected %0d", name,
               mem_log.size() - base, exp_ops.size());
    end else begin
      for (int i = 0; i < exp_ops.size(); i++) begin
        got = mem_log[base + i];
        vectors++;
        if (got !== exp_ops[i]) begin
          miscompares++;
          $display("FAIL %s mem_transfer%0d: got w=%b a=%h d=%h expected w=%b a=%h d=%h", name, i,
                   got.w, got.a, got.d, exp_ops[i].w, exp_ops[i].a, exp_ops[i].d);
        end
      end
    end
    $display("txn %s rd=%b wr=%b addr=%h wdata=%h hit=%b rdata=%h", name, rd, wr, a, wd, !exp_busy, readdata);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    vectors++;
    if ({busywait, mem_read, mem_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy/rd/wr=%b expected 000", {busywait, mem_read, mem_write});
    end
    vectors++;
    if ({mem_address, mem_writedata, readdata} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0", mem_address, mem_writedata, readdata);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_read_miss();
    run_access(1'b1, 1'b0, 8'h24, 8'h00, "read_miss_24");
  endtask

  task automatic test_read_hit();
    run_access(1'b1, 1'b0, 8'h25, 8'h00, "read_hit_25");
  endtask

  task automatic test_writeback();
    run_access(1'b0, 1'b1, 8'h26, 8'hA5, "write_hit_26");
    run_access(1'b1, 1'b0, 8'h46, 8'h00, "read_evict_46");
    idle();
    vectors++;
    if (mem[8'h26] !== 8'hA5) begin
      miscompares++;
      $display("FAIL writeback_mem26: got %h expected a5", mem[8'h26]);
    end
  endtask

  task automatic test_both_high();
    run_access(1'b1, 1'b1, 8'h10, 8'h33, "both_high_10");
    idle();
    run_access(1'b1, 1'b0, 8'h10, 8'h00, "read_after_both_10");
    idle();
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    @(negedge clock);
    read    = 1'b1;
    write   = 1'b0;
    address = 8'h88;
    cyc = 0;
    while (!(mem_read === 1'b1 && mem_address[1:0] == 2'd2) && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    vectors++;
    if (cyc >= 500) begin
      miscompares++;
      $display("FAIL reset_mid_reach_beat2: got no beat-2 read after %0d cycles, expected one", cyc);
    end
    reset = 1'b1;
    read  = 1'b0;
    @(negedge clock);
    #1;
    vectors++;
    if ({mem_read, mem_write, busywait} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got rd/wr/busy=%b expected 000", {mem_read, mem_write, busywait});
    end
    reset = 1'b0;
    model_clear();
    run_access(1'b1, 1'b0, 8'h88, 8'h00, "reread_88");
    idle();
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 8'hE0, 8'h00, "b2b_miss_e0");
    run_access(1'b0, 1'b1, 8'h01, 8'h5A, "b2b_miss_01");
    run_access(1'b1, 1'b0, 8'h22, 8'h00, "b2b_evict_22");
    run_access(1'b1, 1'b0, 8'h01, 8'h00, "b2b_refill_01");
    idle();
  endtask

  task automatic test_random();
    int r;
    logic rd;
    logic wr;
    logic [7:0] a;
    for (int n = 0; n < 200; n++) begin
      r  = int'($urandom_range(0, 7));
      rd = (r == 0) || (r < 4);
      wr = (r == 0) || (r >= 4);
      a  = {3'($urandom_range(0, 3)), 5'($urandom)};
      run_access(rd, wr, a, 8'($urandom), $sformatf("rand%0d", n));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
  endtask

  task automatic test_protocol();
    vectors++;
    if (proto_err != 0) begin
      miscompares++;
      $display("FAIL mem_protocol: got %0d violations expected 0", proto_err);
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    run_access(1'b1, 1'b0, 8'h30, 8'h00, "stats_miss_30");
    run_access(1'b1, 1'b0, 8'h31, 8'h00, "stats_hit_31");
    run_access(1'b0, 1'b1, 8'h32, 8'h77, "stats_hit_32");
    run_access(1'b1, 1'b0, 8'h50, 8'h00, "stats_miss_50");
    idle();
    #1;
    vectors++;
    if (hit_count !== 16'd2 || miss_count !== 16'd2) begin
      miscompares++;
      $display("FAIL stats_counts: got hit=%0d miss=%0d expected 2 2", hit_count, miss_count);
    end
    do_reset();
    #1;
    vectors++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_reset: got hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    model_clear();
    test_reset();
    test_read_miss();
    test_read_hit();
    test_writeback();
    test_both_high();
    test_reset_mid_fetch();
    test_back_to_back();
    test_random();
    test_protocol();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
